avr_xmem_fifo: RTL and testbench

AVR_XMEM_FIFO -- requirements
Module: avr_xmem_fifo

---
 rtl/avr_xmem_fifo.sv | 194 +++++++++++++++++++
 tb/tb_avr_xmem_fifo.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/avr_xmem_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : avr_xmem_fifo
//  Description : Byte FIFO bridge on the AVR external data-memory bus.
//                This block connects an AVR bus window to two byte streams:
//                - AVR -> host (TX)
//                - host -> AVR (RX)
//                A read inserts one wait state. A write completes in the
//                cycle it is issued.
//  Revision    : 1.0 - initial release
// ============================================================================
module avr_xmem_fifo #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] xm_adr,
    input  logic [7:0]  xm_din,
    input  logic        xm_cs,
    input  logic        xm_re,
    input  logic        xm_we,
    output logic [7:0]  xm_dout,
    output logic        xm_wait,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        irq
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [2:0]  OFF_DATA = 3'd0;
    localparam logic [2:0]  OFF_STAT = 3'd1;
    localparam logic [2:0]  OFF_RXCN = 3'd2;
    localparam logic [2:0]  OFF_TXCN = 3'd3;
    localparam logic [2:0]  OFF_CTRL = 3'd4;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_RD_DONE = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    rdata_q, rdata_d;
    logic [7:0]    rx_mem_q [DEPTH];
    logic [7:0]    tx_mem_q [DEPTH];
    logic [AW-1:0] rx_wp_q, rx_rp_q, tx_wp_q, tx_rp_q;
    logic [AW:0]   rx_cnt_q, tx_cnt_q;
    logic          txovf_q, rxunf_q, rxie_q, txeie_q;

    logic [2:0] w_off;
    logic       w_wr, w_rd_start;
    logic       w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
    logic       w_rx_push, w_rx_pop, w_rx_flush;
    logic       w_tx_push, w_tx_pop, w_tx_flush;
    logic [7:0] w_status, w_rx_cnt8, w_tx_cnt8, w_rd_val;
    logic       w_unused_adr;

    // Only the low three address bits select a register.
    assign w_off        = xm_adr[2:0];
    assign w_unused_adr = ^xm_adr[15:3];
    assign w_wr         = xm_cs & xm_we;

    assign w_rx_empty = (rx_cnt_q == '0);
    assign w_rx_full  = (rx_cnt_q == FULL_CNT);
    assign w_tx_empty = (tx_cnt_q == '0);
    assign w_tx_full  = (tx_cnt_q == FULL_CNT);

    assign w_rx_push  = rx_valid & ~w_rx_full;
    assign w_rx_pop   = w_rd_start & (w_off == OFF_DATA) & ~w_rx_empty;
    assign w_rx_flush = w_wr & (w_off == OFF_CTRL) & xm_din[2];
    assign w_tx_push  = w_wr & (w_off == OFF_DATA) & ~w_tx_full;
    assign w_tx_pop   = ~w_tx_empty & tx_ready;
    assign w_tx_flush = w_wr & (w_off == OFF_CTRL) & xm_din[3];

    assign w_status = {3'b000, w_tx_empty, rxunf_q, txovf_q, w_tx_full, ~w_rx_empty};

    // Zero-extend the occupancy counters onto the 8-bit data bus.
    always_comb begin
        w_rx_cnt8       = '0;
        w_tx_cnt8       = '0;
        w_rx_cnt8[AW:0] = rx_cnt_q;
        w_tx_cnt8[AW:0] = tx_cnt_q;
    end

    // Register read mux; an empty RX FIFO returns zero on DATA.
    always_comb begin
        w_rd_val = 8'h00;
        case (w_off)
            OFF_DATA: w_rd_val = w_rx_empty ? 8'h00 : rx_mem_q[rx_rp_q];
            OFF_STAT: w_rd_val = w_status;
            OFF_RXCN: w_rd_val = w_rx_cnt8;
            OFF_TXCN: w_rd_val = w_tx_cnt8;
            OFF_CTRL: w_rd_val = {6'b000000, txeie_q, rxie_q};
            default:  w_rd_val = 8'h00;
        endcase
    end

    // Read handshake: stall one cycle while the value is captured, then present it.
    always_comb begin
        state_d    = state_q;
        rdata_d    = rdata_q;
        xm_wait    = 1'b0;
        w_rd_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (xm_cs && xm_re && !xm_we) begin
                    xm_wait    = 1'b1;
                    w_rd_start = 1'b1;
                    rdata_d    = w_rd_val;
                    state_d    = ST_RD_DONE;
                end
            end
            ST_RD_DONE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Read state and captured read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    // RX FIFO pointers and occupancy; flush beats push and pop.
    always_ff @(posedge clk) begin
        if (rst || w_rx_flush) begin
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (w_rx_push) rx_wp_q <= rx_wp_q + AW'(1);
            if (w_rx_pop)  rx_rp_q <= rx_rp_q + AW'(1);
            if (w_rx_push && !w_rx_pop)      rx_cnt_q <= rx_cnt_q + (AW+1)'(1);
            else if (w_rx_pop && !w_rx_push) rx_cnt_q <= rx_cnt_q - (AW+1)'(1);
        end
    end

    // TX FIFO pointers and occupancy; flush beats push and pop.
    always_ff @(posedge clk) begin
        if (rst || w_tx_flush) begin
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_cnt_q <= '0;
        end else begin
            if (w_tx_push) tx_wp_q <= tx_wp_q + AW'(1);
            if (w_tx_pop)  tx_rp_q <= tx_rp_q + AW'(1);
            if (w_tx_push && !w_tx_pop)      tx_cnt_q <= tx_cnt_q + (AW+1)'(1);
            else if (w_tx_pop && !w_tx_push) tx_cnt_q <= tx_cnt_q - (AW+1)'(1);
        end
    end

    // FIFO storage; contents are don't-care while the pointers mark them empty.
    always_ff @(posedge clk) begin
        if (w_rx_push) rx_mem_q[rx_wp_q] <= rx_data;
        if (w_tx_push) tx_mem_q[tx_wp_q] <= xm_din;
    end

    // Sticky error flags (write-1-to-clear) and interrupt enables.
    always_ff @(posedge clk) begin
        if (rst) begin
            txovf_q <= 1'b0;
            rxunf_q <= 1'b0;
            rxie_q  <= 1'b0;
            txeie_q <= 1'b0;
        end else begin
            if (w_wr && (w_off == OFF_STAT)) begin
                if (xm_din[2]) txovf_q <= 1'b0;
                if (xm_din[3]) rxunf_q <= 1'b0;
            end
            if (w_wr && (w_off == OFF_DATA) && w_tx_full)         txovf_q <= 1'b1;
            if (w_rd_start && (w_off == OFF_DATA) && w_rx_empty) rxunf_q <= 1'b1;
            if (w_wr && (w_off == OFF_CTRL)) begin
                rxie_q  <= xm_din[0];
                txeie_q <= xm_din[1];
            end
        end
    end

    assign xm_dout  = rdata_q;
    assign tx_valid = ~w_tx_empty;
    assign tx_data  = tx_mem_q[tx_rp_q];
    assign rx_ready = ~w_rx_full;
    assign irq      = (rxie_q & ~w_rx_empty) | (txeie_q & w_tx_empty);

endmodule
`default_nettype wire

// File: tb/tb_avr_xmem_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_avr_xmem_fifo
//  Description : Scoreboard testbench for avr_xmem_fifo. Directed scenarios
//                are followed by a randomized phase. A queue-based reference
//                model predicts the expected behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_avr_xmem_fifo;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] xm_adr = '0;
    logic [7:0]  xm_din = '0;
    logic        xm_cs = 1'b0, xm_re = 1'b0, xm_we = 1'b0;
    logic [7:0]  xm_dout;
    logic        xm_wait;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        irq;

    avr_xmem_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .xm_adr(xm_adr), .xm_din(xm_din),
        .xm_cs(xm_cs), .xm_re(xm_re), .xm_we(xm_we),
        .xm_dout(xm_dout), .xm_wait(xm_wait),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .irq(irq)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    logic [7:0] expq[$];
    bit m_txovf = 0, m_rxunf = 0, m_rxie = 0, m_txeie = 0, m_rd_done = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_read(input logic [2:0] off);
        case (off)
            3'd0: return (rxq.size() != 0) ? rxq[0] : 8'h00;
            3'd1: return {3'b000, txq.size() == 0, m_rxunf, m_txovf,
                          txq.size() == DEPTH, rxq.size() != 0};
            3'd2: return 8'(rxq.size());
            3'd3: return 8'(txq.size());
            3'd4: return {6'b000000, m_txeie, m_rxie};
            default: return 8'h00;
        endcase
    endfunction

    // Monitor: compares read data when presented and every TX handshake.
    bit mon_rd_pending = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (mon_rd_pending) begin
                if (expq.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL rd_unexpected: got %02h expected no read", xm_dout);
                end else begin
                    check("rd_data", xm_dout, expq.pop_front());
                end
            end
            mon_rd_pending = (xm_wait === 1'b1);
            if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
                if (txq.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL tx_unexpected: got %02h expected no byte", tx_data);
                end else begin
                    check("tx_data", tx_data, txq.pop_front());
                end
            end
        end
    end

    // One bus cycle: drive, predict, check mid-cycle, then advance the model.
    task automatic cyc(input bit r, input bit cs, input bit re, input bit we,
                       input logic [2:0] off, input logic [7:0] din,
                       input bit rxv, input logic [7:0] rxd, input int edout);
        bit rd_issue, wr, ex_wait, ex_rdy, ex_txv, ex_irq;
        bit rx_acc, rx_pop, tx_push, rxfl, txfl;
        rst = r; xm_cs = cs; xm_re = re; xm_we = we;
        xm_adr = {13'($urandom), off};
        xm_din = din; rx_valid = rxv; rx_data = rxd;
        ex_wait  = !m_rd_done && cs && re && !we;
        rd_issue = ex_wait && !r;
        wr       = cs && we;
        ex_rdy   = rxq.size() < DEPTH;
        ex_txv   = txq.size() != 0;
        ex_irq   = (m_rxie && rxq.size() != 0) || (m_txeie && txq.size() == 0);
        if (rd_issue) expq.push_back(model_read(off));
        rx_acc  = rxv && ex_rdy;
        rx_pop  = rd_issue && off == 3'd0 && rxq.size() != 0;
        tx_push = wr && off == 3'd0 && txq.size() < DEPTH;
        rxfl    = wr && off == 3'd4 && din[2];
        txfl    = wr && off == 3'd4 && din[3];
        @(negedge clk);
        if (!r) begin
            check("xm_wait",  {7'b0, xm_wait},  {7'b0, ex_wait});
            check("rx_ready", {7'b0, rx_ready}, {7'b0, ex_rdy});
            check("tx_valid", {7'b0, tx_valid}, {7'b0, ex_txv});
            check("irq",      {7'b0, irq},      {7'b0, ex_irq});
            if (edout >= 0) check("dout_after_rst", xm_dout, 8'(edout));
        end
        @(posedge clk); #1;
        if (r) begin
            rxq.delete(); txq.delete();
            m_txovf = 0; m_rxunf = 0; m_rxie = 0; m_txeie = 0; m_rd_done = 0;
        end else begin
            if (rd_issue && off == 3'd0 && !rx_pop) m_rxunf = 1;
            if (rxfl) rxq.delete();
            else begin
                if (rx_pop) void'(rxq.pop_front());
                if (rx_acc) rxq.push_back(rxd);
            end
            if (wr && off == 3'd0 && !tx_push) m_txovf = 1;
            if (txfl) txq.delete();
            else if (tx_push) txq.push_back(din);
            if (wr && off == 3'd1) begin
                if (din[2]) m_txovf = 0;
                if (din[3]) m_rxunf = 0;
            end
            if (wr && off == 3'd4) begin
                m_rxie = din[0]; m_txeie = din[1];
            end
            m_rd_done = rd_issue;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 3'd0, 8'h00, 0, 8'h00, -1);
    endtask
    task automatic host_push(input logic [7:0] d);
        cyc(0, 0, 0, 0, 3'd0, 8'h00, 1, d, -1);
    endtask
    task automatic wr(input logic [2:0] off, input logic [7:0] d, input bit rxv, input logic [7:0] rxd);
        cyc(0, 1, 0, 1, off, d, rxv, rxd, -1);
    endtask
    task automatic rd(input logic [2:0] off, input bit rxv, input logic [7:0] rxd);
        cyc(0, 1, 1, 0, off, 8'h00, rxv, rxd, -1);
        cyc(0, 1, 1, 0, off, 8'h00, 0, 8'h00, -1);
    endtask
    task automatic do_reset();
        cyc(1, 0, 0, 0, 3'd0, 8'h00, 0, 8'h00, -1);
        cyc(1, 0, 0, 0, 3'd0, 8'h00, 0, 8'h00, -1);
        cyc(0, 0, 0, 0, 3'd0, 8'h00, 0, 8'h00, 0);
    endtask

    initial begin
        @(posedge clk); #1;
        do_reset();

        // Host sends three bytes; AVR reads count then data each time.
        host_push(8'h11); host_push(8'h22); host_push(8'h33);
        for (int i = 0; i < 3; i++) begin
            rd(3'd2, 0, 8'h00);
            rd(3'd0, 0, 8'h00);
        end

        // Underflow: empty DATA read, STATUS shows RXUNF, count zero, clear it.
        rd(3'd0, 0, 8'h00);
        rd(3'd1, 0, 8'h00);
        rd(3'd2, 0, 8'h00);
        wr(3'd1, 8'h08, 0, 8'h00);

        // TX overflow with the host stalled, then drain in order.
        tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) wr(3'd0, 8'(8'hA0 + i), 0, 8'h00);
        rd(3'd3, 0, 8'h00);
        rd(3'd1, 0, 8'h00);
        tx_ready = 1'b1;
        for (int i = 0; i < 40 && txq.size() != 0; i++) idle(1);
        n_tests++;
        if (txq.size() != 0) begin
            n_fail++;
            $display("FAIL tx_drain: got %0d bytes left expected 0", txq.size());
        end
        wr(3'd1, 8'h04, 0, 8'h00);
        rd(3'd1, 0, 8'h00);

        // RX full: pop and offered byte in the same cycle; byte must be refused.
        for (int i = 0; i < DEPTH; i++) host_push(8'(8'h40 + i));
        rd(3'd0, 1, 8'hEE);
        rd(3'd2, 0, 8'h00);
        for (int i = 0; i < DEPTH - 1; i++) rd(3'd0, 0, 8'h00);

        // RX interrupt and flush.
        wr(3'd4, 8'h01, 0, 8'h00);
        idle(1);
        host_push(8'h5A);
        idle(1);
        wr(3'd4, 8'h05, 0, 8'h00);
        idle(1);
        rd(3'd2, 0, 8'h00);
        wr(3'd4, 8'h00, 0, 8'h00);

        // Randomized traffic on every register and both streams.
        for (int i = 0; i < 400; i++) begin
            logic [7:0] d;
            logic [2:0] o;
            bit         v;
            d = 8'($urandom);
            o = 3'($urandom_range(0, 7));
            v = 1'($urandom_range(0, 1));
            tx_ready = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0, 1: rd(o, v, d);
                2:    rd(3'd0, v, d);
                3:    wr(3'd0, d, v, 8'($urandom));
                4:    wr(o, (o == 3'd4) ? (d & 8'hF3) | (($urandom_range(0, 7) == 0) ? 8'h0C : 8'h00) : d,
                         v, 8'($urandom));
                default: cyc(0, 0, 0, 0, 3'd0, 8'h00, v, d, -1);
            endcase
        end
        tx_ready = 1'b0;
        wr(3'd4, 8'h0C, 0, 8'h00);
        wr(3'd1, 8'h0C, 0, 8'h00);
        do_reset();

        // Reset during RD_DONE abandons the read and clears everything.
        wr(3'd4, 8'h01, 0, 8'h00);
        host_push(8'h77); host_push(8'h88);
        rd(3'd2, 0, 8'h00);
        cyc(0, 1, 1, 0, 3'd0, 8'h00, 0, 8'h00, -1);
        cyc(1, 1, 1, 0, 3'd0, 8'h00, 0, 8'h00, -1);
        cyc(0, 0, 0, 0, 3'd0, 8'h00, 0, 8'h00, 0);
        rd(3'd2, 0, 8'h00);
        idle(2);

        n_tests++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL rd_outstanding: got %0d pending expected 0", expq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
